// File: rtl/blockmem_2p_pipe.sv
// ---------------------------------------------------------------------------
// blockmem_2p_pipe
//
// Single-clock simple dual-port block memory. Port A writes (optionally with
// per-byte enables), port B reads through a 1..3 cycle pipeline with a
// one-cycle valid strobe. A sweep engine fills every word with G_CLEAR_VALUE
// after reset and whenever a clear pulse arrives during normal operation.
//
// Configuration macro:
//    BLOCKMEM_2P_PIPE_BYPASS_EN - same-edge, same-address write/read returns
//                                 the write-first merged word; otherwise the
//                                 read returns the pre-write word.
//
// Ports:
//    clk         - clock, rising edge
//    rst         - asynchronous active-high reset
//    clear       - request a sweep (ignored while init_busy)
//    init_busy   - high while the sweep runs
//    ena/wea     - port A enable / write enables (per byte or single)
//    addra/dina  - port A address / data
//    enb/addrb   - port B read request / address
//    doutb       - read data, holds between strobes
//    doutb_valid - one-cycle strobe marking new doutb
// ---------------------------------------------------------------------------
module blockmem_2p_pipe #(
   parameter int                     G_DATAWIDTH   = 32,
   parameter int                     G_MEMDEPTH    = 1024,
   parameter int                     G_BWENABLE    = 0,
   parameter int                     G_RDLATENCY   = 1,
   parameter logic [G_DATAWIDTH-1:0] G_CLEAR_VALUE = '0,
   parameter int                     G_ADDRWIDTH   = $clog2(G_MEMDEPTH),
   parameter int                     G_PADWIDTH    = ((G_DATAWIDTH + 7) / 8) * 8,
   parameter int                     G_WEWIDTH     = (G_BWENABLE != 0) ? G_PADWIDTH / 8 : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   output logic                   init_busy,
   input  logic                   ena,
   input  logic [G_WEWIDTH-1:0]   wea,
   input  logic [G_ADDRWIDTH-1:0] addra,
   input  logic [G_DATAWIDTH-1:0] dina,
   input  logic                   enb,
   input  logic [G_ADDRWIDTH-1:0] addrb,
   output logic [G_DATAWIDTH-1:0] doutb,
   output logic                   doutb_valid
);

   localparam int NBYTES = G_PADWIDTH / 8;
   localparam logic [G_ADDRWIDTH-1:0] LASTADDR = G_ADDRWIDTH'(G_MEMDEPTH - 1);

   if (G_RDLATENCY < 1 || G_RDLATENCY > 3) begin : gBadLatency
      $error("blockmem_2p_pipe: G_RDLATENCY must be 1..3");
   end

   typedef enum logic {
      SWEEP,
      RUN
   } stateT;

   stateT                  state_q, state_d;
   logic [G_ADDRWIDTH-1:0] sweepCnt_q, sweepCnt_d;

   logic [G_PADWIDTH-1:0]  mem [G_MEMDEPTH];
   logic [G_PADWIDTH-1:0]  dinaPad;
   logic [G_PADWIDTH-1:0]  clearPad;
   logic [NBYTES-1:0]      byteEn;
   logic                   wrInRange;
   logic                   rdInRange;
   logic                   isRun;
   logic                   wrEn;
   logic                   rdAccept;
   logic [G_PADWIDTH-1:0]  rdWord;
   logic [G_PADWIDTH-1:0]  rdMerged;
   logic [G_DATAWIDTH-1:0] rdData;

   // Stage 0 holds the word sampled at the accept edge; stage G_RDLATENCY
   // drives the outputs, giving exactly G_RDLATENCY edges of delay.
   logic [G_DATAWIDTH-1:0] pipeData_q  [G_RDLATENCY+1];
   logic                   pipeValid_q [G_RDLATENCY+1];

   assign isRun     = (state_q == RUN);
   assign init_busy = ~isRun;
   assign wrEn      = isRun & ena & wrInRange;
   assign rdAccept  = isRun & enb;

   // Zero-extend write data and the clear value to the byte-padded width.
   always_comb begin
      dinaPad                    = '0;
      dinaPad[G_DATAWIDTH-1:0]   = dina;
      clearPad                   = '0;
      clearPad[G_DATAWIDTH-1:0]  = G_CLEAR_VALUE;
   end

   // With byte enables off, the single enable bit gates every byte.
   if (G_BWENABLE != 0) begin : gByteEn
      assign byteEn = wea;
   end else begin : gWordEn
      assign byteEn = {NBYTES{wea[0]}};
   end

   // Power-of-two depths cover the whole address space; otherwise the upper
   // addresses must be filtered out.
   if (G_MEMDEPTH == (1 << G_ADDRWIDTH)) begin : gFullRange
      assign wrInRange = 1'b1;
      assign rdInRange = 1'b1;
   end else begin : gPartRange
      assign wrInRange = (32'(addra) < 32'(G_MEMDEPTH));
      assign rdInRange = (32'(addrb) < 32'(G_MEMDEPTH));
   end

   // Sweep/run state register; reset restarts the sweep from address 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= SWEEP;
         sweepCnt_q <= '0;
      end else begin
         state_q    <= state_d;
         sweepCnt_q <= sweepCnt_d;
      end
   end

   // Next-state logic: walk every address once, then run until a clear pulse.
   always_comb begin
      state_d    = state_q;
      sweepCnt_d = sweepCnt_q;
      case (state_q)
         SWEEP: begin
            if (sweepCnt_q == LASTADDR) begin
               state_d    = RUN;
               sweepCnt_d = '0;
            end else begin
               sweepCnt_d = sweepCnt_q + G_ADDRWIDTH'(1);
            end
         end
         RUN: begin
            if (clear) begin
               state_d    = SWEEP;
               sweepCnt_d = '0;
            end
         end
         default: begin
            state_d    = SWEEP;
            sweepCnt_d = '0;
         end
      endcase
   end

   // Storage array: the sweep owns the write port while it runs, otherwise
   // port A updates the enabled bytes. Contents are never reset directly.
   always_ff @(posedge clk) begin
      if (state_q == SWEEP) begin
         mem[sweepCnt_q] <= clearPad;
      end else if (wrEn) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (byteEn[b]) begin
               mem[addra][8*b +: 8] <= dinaPad[8*b +: 8];
            end
         end
      end
   end

   assign rdWord = mem[addrb];

`ifdef BLOCKMEM_2P_PIPE_BYPASS_EN
   // Forward the bytes being written this edge so the read sees write-first data.
   always_comb begin
      rdMerged = rdWord;
      if (wrEn && (addra == addrb)) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (byteEn[b]) begin
               rdMerged[8*b +: 8] = dinaPad[8*b +: 8];
            end
         end
      end
   end
`else
   assign rdMerged = rdWord;
`endif

   // Out-of-range reads return the clear value, as if the word had been swept.
   assign rdData = rdInRange ? rdMerged[G_DATAWIDTH-1:0] : G_CLEAR_VALUE;

   // Read pipeline: valid bits shift every cycle, data only moves with a
   // valid so the output stage holds its last value between strobes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s <= G_RDLATENCY; s++) begin
            pipeData_q[s]  <= '0;
            pipeValid_q[s] <= 1'b0;
         end
      end else begin
         pipeValid_q[0] <= rdAccept;
         if (rdAccept) begin
            pipeData_q[0] <= rdData;
         end
         for (int s = 1; s <= G_RDLATENCY; s++) begin
            pipeValid_q[s] <= pipeValid_q[s-1];
            if (pipeValid_q[s-1]) begin
               pipeData_q[s] <= pipeData_q[s-1];
            end
         end
      end
   end

   assign doutb       = pipeData_q[G_RDLATENCY];
   assign doutb_valid = pipeValid_q[G_RDLATENCY];

endmodule

// File: tb/tb_blockmem_2p_pipe.sv
// ---------------------------------------------------------------------------
// tb_blockmem_2p_pipe
//
// Scoreboard bench for blockmem_2p_pipe configured with 16 words, byte
// enables, read latency 3 and clear value DEADBEEF. Reads push the expected
// word and arrival cycle into a queue; a monitor pops on every valid strobe.
// ---------------------------------------------------------------------------
module tb_blockmem_2p_pipe;

   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int LAT   = 3;
   localparam logic [31:0] CLRV = 32'hDEAD_BEEF;

   logic        clk;
   logic        rst;
   logic        clear;
   logic        init_busy;
   logic        ena;
   logic [3:0]  wea;
   logic [3:0]  addra;
   logic [31:0] dina;
   logic        enb;
   logic [3:0]  addrb;
   logic [31:0] doutb;
   logic        doutb_valid;

   typedef struct {
      logic [31:0] data;
      int          due;
   } expT;

   expT sbQ[$];
   int  testsRun = 0;
   int  testsFailed = 0;
   int  cyc = 0;

   blockmem_2p_pipe #(
      .G_DATAWIDTH   (DW),
      .G_MEMDEPTH    (DEPTH),
      .G_BWENABLE    (1),
      .G_RDLATENCY   (LAT),
      .G_CLEAR_VALUE (CLRV)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .clear       (clear),
      .init_busy   (init_busy),
      .ena         (ena),
      .wea         (wea),
      .addra       (addra),
      .dina        (dina),
      .enb         (enb),
      .addrb       (addrb),
      .doutb       (doutb),
      .doutb_valid (doutb_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count rising edges so the monitor can check arrival timing.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      testsRun++;
      if (actual !== required) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, required, cyc);
      end
   endtask

   // Drive one cycle of port activity; a qualified read records its expectation.
   task automatic applyStimulus(input logic enA, input logic [3:0] we, input logic [3:0] aA,
                                input logic [31:0] dA, input logic enB, input logic [3:0] aB,
                                input logic doExp, input logic [31:0] expData);
      ena   = enA;
      wea   = we;
      addra = aA;
      dina  = dA;
      enb   = enB;
      addrb = aB;
      if (enB && doExp) sbQ.push_back('{expData, cyc + 1 + LAT});
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 4'h0, 4'h0, 32'h0, 0, 4'h0, 0, 32'h0);
   endtask

   // Count how many sampled cycles init_busy stays high, bounded.
   task automatic countBusy(output int n);
      n = 0;
      while (init_busy && n < 100) begin
         n++;
         idle(1);
      end
   endtask

   // Monitor: every valid strobe must match the oldest outstanding read.
   always @(negedge clk) begin
      if (doutb_valid) begin
         if (sbQ.size() == 0) begin
            checkOutput("unexpected valid", 32'(doutb_valid), 32'h0);
         end else begin
            expT e;
            e = sbQ.pop_front();
            checkOutput("read data", doutb, e.data);
            checkOutput("read arrival cycle", 32'(cyc), 32'(e.due));
         end
      end
   end

   initial begin
      int n;
      rst   = 1'b1;
      clear = 1'b0;
      ena   = 1'b0;
      wea   = '0;
      addra = '0;
      dina  = '0;
      enb   = 1'b0;
      addrb = '0;
      repeat (2) @(negedge clk);
      checkOutput("reset doutb", doutb, 32'h0);
      checkOutput("reset valid", 32'(doutb_valid), 32'h0);
      checkOutput("reset init_busy", 32'(init_busy), 32'h1);
      rst = 1'b0;
      countBusy(n);
      checkOutput("init_busy after reset", 32'(n), 32'(DEPTH));

      // Every word holds the clear value after the initial sweep.
      for (int a = 0; a < DEPTH; a++) applyStimulus(0, 4'h0, 4'h0, 32'h0, 1, 4'(a), 1, CLRV);
      idle(LAT + 2);

      // Write addr*3, then read 0..7 back-to-back.
      for (int a = 0; a < 8; a++) applyStimulus(1, 4'hF, 4'(a), 32'(a * 3), 0, 4'h0, 0, 32'h0);
      for (int a = 0; a < 8; a++) applyStimulus(0, 4'h0, 4'h0, 32'h0, 1, 4'(a), 1, 32'(a * 3));
      idle(LAT + 2);

      // Byte-enable merge.
      applyStimulus(1, 4'hF, 4'd9, 32'h1122_3344, 0, 4'h0, 0, 32'h0);
      applyStimulus(1, 4'b0101, 4'd9, 32'hAABB_CCDD, 0, 4'h0, 0, 32'h0);
      applyStimulus(0, 4'h0, 4'h0, 32'h0, 1, 4'd9, 1, 32'h11BB_33DD);
      idle(LAT + 2);

      // Same-edge write and read of one address.
      applyStimulus(1, 4'hF, 4'd2, 32'h9, 0, 4'h0, 0, 32'h0);
`ifdef BLOCKMEM_2P_PIPE_BYPASS_EN
      applyStimulus(1, 4'hF, 4'd2, 32'h5, 1, 4'd2, 1, 32'h5);
`else
      applyStimulus(1, 4'hF, 4'd2, 32'h5, 1, 4'd2, 1, 32'h9);
`endif
      applyStimulus(0, 4'h0, 4'h0, 32'h0, 1, 4'd2, 1, 32'h5);
      idle(LAT + 2);

      // Clear pulse: writes and reads during the sweep are dropped.
      clear = 1'b1;
      idle(1);
      clear = 1'b0;
      n = 0;
      while (init_busy && n < 100) begin
         n++;
         applyStimulus(1, 4'hF, 4'(n), 32'h1234, 1, 4'(n), 0, 32'h0);
      end
      checkOutput("init_busy after clear", 32'(n), 32'(DEPTH));
      idle(LAT + 2);
      for (int a = 0; a < DEPTH; a++) applyStimulus(0, 4'h0, 4'h0, 32'h0, 1, 4'(a), 1, CLRV);
      idle(LAT + 2);

      // Reset in the middle of a sweep restarts it.
      clear = 1'b1;
      idle(1);
      clear = 1'b0;
      idle(7);
      rst = 1'b1;
      #1;
      checkOutput("mid-sweep reset doutb", doutb, 32'h0);
      checkOutput("mid-sweep reset valid", 32'(doutb_valid), 32'h0);
      checkOutput("mid-sweep reset init_busy", 32'(init_busy), 32'h1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      countBusy(n);
      checkOutput("init_busy after mid-sweep reset", 32'(n), 32'(DEPTH));
      applyStimulus(0, 4'h0, 4'h0, 32'h0, 1, 4'd7, 1, CLRV);
      applyStimulus(0, 4'h0, 4'h0, 32'h0, 1, 4'd12, 1, CLRV);
      idle(LAT + 3);

      checkOutput("scoreboard drained", 32'(sbQ.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
